qspi_flash_resp: RTL and testbench

Single-lane SPI flash responder that sits on the SoC's QSPI pads opposite the QSPI controller, serving instruction/data fetches in simulation and FPGA bring-up. It oversamples SCK/CS/DQ0 from the controller on `sys_clk` and decodes READ (0x03) and READ-ID (0x9F) commands. It returns data on DQ1 from an internal byte memory preloaded through a side port. SPI mode 0 only: CPOL=0, CPHA=0, MSB first.

---
 rtl/qspi_flash_resp.sv | 180 ++++++++++++++++++
 tb/tb_qspi_flash_resp.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_resp.sv
// Single-lane SPI (mode 0) flash responder: decodes READ (0x03) and READ-ID (0x9F),
// returns bytes on MISO from a preloadable internal memory. Pads are oversampled on sys_clk.
module qspi_flash_resp #(
  parameter int          MEM_AW   = 10,
  parameter logic [23:0] JEDEC_ID = 24'hEF4017
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              qspi_sck,
  input  logic              qspi_cs_n,
  input  logic              qspi_mosi,
  output logic              qspi_miso,
  input  logic              ld_en,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic [15:0]       cmd_cnt,
  output logic              bad_cmd
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

  state_t              state_reg;
  logic [2:0]          sck_sync_reg;
  logic [1:0]          cs_sync_reg;
  logic [1:0]          mosi_sync_reg;
  logic [4:0]          bit_cnt_reg;
  logic [6:0]          rx_sr_reg;
  logic [6:0]          tx_sr_reg;
  logic [MEM_AW-1:0]   ptr_reg;
  logic [1:0]          id_idx_reg;
  logic                src_id_reg;
  logic [7:0]          rd_data_reg;
  logic [7:0]          mem [0:(1<<MEM_AW)-1];
  logic [7:0]          id_byte [0:3];

  logic                sck_rise;
  logic                sck_fall;
  logic                cs_high;
  logic                mosi_s;
  logic [7:0]          cmd_byte;
  logic [7:0]          fetch_byte;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sck_sync_reg  <= 3'b000;
      cs_sync_reg   <= 2'b11;
      mosi_sync_reg <= 2'b00;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[1:0], qspi_sck};
      cs_sync_reg   <= {cs_sync_reg[0], qspi_cs_n};
      mosi_sync_reg <= {mosi_sync_reg[0], qspi_mosi};
    end
  end

  assign sck_rise = sck_sync_reg[1] & ~sck_sync_reg[2];
  assign sck_fall = ~sck_sync_reg[1] & sck_sync_reg[2];
  assign cs_high  = cs_sync_reg[1];
  assign mosi_s   = mosi_sync_reg[1];
  assign cmd_byte = {rx_sr_reg, mosi_s};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_id
      assign id_byte[gi] = JEDEC_ID[8*(2-gi) +: 8];
    end
  endgenerate
  assign id_byte[3] = 8'h00;

  // Read is free-running on the pointer; the pointer settles at least two
  // cycles before the fetching SCK fall, so rd_data_reg is always current.
  always_ff @(posedge sys_clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
    rd_data_reg <= mem[ptr_reg];
  end

  assign fetch_byte = src_id_reg ? id_byte[id_idx_reg] : rd_data_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg   <= ST_IDLE;
      qspi_miso   <= 1'b1;
      cmd_cnt     <= 16'd0;
      bad_cmd     <= 1'b0;
      bit_cnt_reg <= 5'd0;
      rx_sr_reg   <= 7'd0;
      tx_sr_reg   <= 7'd0;
      ptr_reg     <= '0;
      id_idx_reg  <= 2'd0;
      src_id_reg  <= 1'b0;
    end else if (cs_high) begin
      // CS release wins over a coincident SCK edge; partial bytes are dropped.
      state_reg   <= ST_IDLE;
      qspi_miso   <= 1'b1;
      bit_cnt_reg <= 5'd0;
      id_idx_reg  <= 2'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_reg   <= ST_CMD;
          bit_cnt_reg <= 5'd0;
          qspi_miso   <= 1'b1;
        end
        ST_CMD: begin
          if (sck_rise) begin
            rx_sr_reg   <= cmd_byte[6:0];
            bit_cnt_reg <= bit_cnt_reg + 5'd1;
            if (bit_cnt_reg == 5'd7) begin
              bit_cnt_reg <= 5'd0;
              case (cmd_byte)
                8'h03: begin
                  state_reg <= ST_ADDR;
                  cmd_cnt   <= cmd_cnt + 16'd1;
                end
                8'h9F: begin
                  state_reg  <= ST_DATA;
                  src_id_reg <= 1'b1;
                  id_idx_reg <= 2'd0;
                  cmd_cnt    <= cmd_cnt + 16'd1;
                end
                default: begin
                  state_reg <= ST_IGNORE;
                  bad_cmd   <= 1'b1;
                end
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            // Only the low MEM_AW address bits survive the shift (aliasing).
            ptr_reg     <= {ptr_reg[MEM_AW-2:0], mosi_s};
            bit_cnt_reg <= bit_cnt_reg + 5'd1;
            if (bit_cnt_reg == 5'd23) begin
              state_reg   <= ST_DATA;
              src_id_reg  <= 1'b0;
              bit_cnt_reg <= 5'd0;
            end
          end
        end
        ST_DATA: begin
          if (sck_rise) begin
            bit_cnt_reg <= {2'b00, bit_cnt_reg[2:0] + 3'd1};
            if (bit_cnt_reg[2:0] == 3'd7) begin
              if (src_id_reg) begin
                if (id_idx_reg != 2'd3) begin
                  id_idx_reg <= id_idx_reg + 2'd1;
                end
              end else begin
                ptr_reg <= ptr_reg + 1'b1;
              end
            end
          end else if (sck_fall) begin
            if (bit_cnt_reg[2:0] == 3'd0) begin
              tx_sr_reg <= fetch_byte[6:0];
              qspi_miso <= fetch_byte[7];
            end else begin
              tx_sr_reg <= {tx_sr_reg[5:0], 1'b0};
              qspi_miso <= tx_sr_reg[6];
            end
          end
        end
        ST_IGNORE: begin
          qspi_miso <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_flash_resp.sv
// Bench for qspi_flash_resp: table of directed reads, hand-written abort/reset
// sequences, then random reads checked against a byte-array model.
module tb_qspi_flash_resp;

  localparam int HALF = 4;

  logic        sys_clk;
  logic        sys_rst;
  logic        qspi_sck;
  logic        qspi_cs_n;
  logic        qspi_mosi;
  logic        qspi_miso;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [15:0] cmd_cnt;
  logic        bad_cmd;

  int passed = 0;
  int total  = 0;

  logic [7:0]  mem_model [0:1023];
  logic [15:0] cnt_model;
  logic        bad_model;

  typedef struct {
    string       name;
    logic        ld_do;
    logic [9:0]  ld_a;
    logic [7:0]  ld_d;
    logic [7:0]  op;
    logic [23:0] addr;
    logic        with_addr;
    int          dbits;
    logic [63:0] exp_rx;
    logic [15:0] exp_cnt;
    logic        exp_bad;
  } vec_t;

  vec_t vecs [6];

  qspi_flash_resp #(.MEM_AW(10), .JEDEC_ID(24'hEF4017)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .qspi_sck  (qspi_sck),
    .qspi_cs_n (qspi_cs_n),
    .qspi_mosi (qspi_mosi),
    .qspi_miso (qspi_miso),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .cmd_cnt   (cmd_cnt),
    .bad_cmd   (bad_cmd)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic load(input logic [9:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    wait_clk(1);
    ld_en   = 1'b0;
    mem_model[a] = d;
  endtask

  task automatic spi_bit(input logic b, output logic s);
    qspi_mosi = b;
    wait_clk(HALF);
    s = qspi_miso;
    qspi_sck = 1'b1;
    wait_clk(HALF);
    qspi_sck = 1'b0;
  endtask

  task automatic spi_read(input logic [7:0] op, input logic [23:0] addr, input logic with_addr,
                          input int dbits, output logic [63:0] rx, output logic pre_ones);
    logic s;
    rx = '0;
    pre_ones = 1'b1;
    qspi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 8; i++) begin
      spi_bit(op[7-i], s);
      if (s !== 1'b1) pre_ones = 1'b0;
    end
    if (with_addr) begin
      for (int i = 0; i < 24; i++) begin
        spi_bit(addr[23-i], s);
        if (s !== 1'b1) pre_ones = 1'b0;
      end
    end
    for (int i = 0; i < dbits; i++) begin
      spi_bit(1'b0, s);
      rx = {rx[62:0], s};
    end
    wait_clk(HALF);
    qspi_cs_n = 1'b1;
    wait_clk(8);
    $display("xfer op=%02h addr=%06h bits=%0d rx=%0h cnt=%0d bad=%0b", op, addr, dbits, rx, cmd_cnt, bad_cmd);
  endtask

  function automatic logic [63:0] model_read(input logic [7:0] op, input logic [23:0] addr, input int nbytes);
    logic [63:0] r;
    logic [7:0]  b;
    r = '0;
    for (int i = 0; i < nbytes; i++) begin
      if (op == 8'h03)      b = mem_model[(int'(addr[9:0]) + i) % 1024];
      else if (op == 8'h9F) b = (i == 0) ? 8'hEF : (i == 1) ? 8'h40 : (i == 2) ? 8'h17 : 8'h00;
      else                  b = 8'hFF;
      r = {r[55:0], b};
    end
    return r;
  endfunction

  initial begin
    logic [63:0] rx;
    logic        pre;
    logic        s;
    logic [7:0]  op;
    logic [23:0] addr;
    int          nb;
    int          kind;

    sys_rst = 1'b1; qspi_sck = 1'b0; qspi_cs_n = 1'b1; qspi_mosi = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    wait_clk(3);
    sys_rst = 1'b0;
    wait_clk(2);
    check("reset_miso", {63'd0, qspi_miso}, 64'd1);
    check("reset_cnt",  {48'd0, cmd_cnt},   64'd0);
    check("reset_bad",  {63'd0, bad_cmd},   64'd0);

    for (int i = 0; i < 1024; i++) load(i[9:0], 8'($urandom));
    load(10'h000, 8'h11); load(10'h001, 8'h22); load(10'h002, 8'h33);
    load(10'h003, 8'h44); load(10'h3FF, 8'hA5);

    vecs[0] = '{"read4",   1'b0, 10'h000, 8'h00, 8'h03, 24'h000000, 1'b1, 32, 64'h11223344,   16'd1, 1'b0};
    vecs[1] = '{"jedec",   1'b0, 10'h000, 8'h00, 8'h9F, 24'h000000, 1'b0, 40, 64'hEF40170000, 16'd2, 1'b0};
    vecs[2] = '{"wrap",    1'b1, 10'h000, 8'h5A, 8'h03, 24'h0003FF, 1'b1, 16, 64'hA55A,       16'd3, 1'b0};
    vecs[3] = '{"alias",   1'b0, 10'h000, 8'h00, 8'h03, 24'h8003FF, 1'b1, 8,  64'hA5,         16'd4, 1'b0};
    vecs[4] = '{"badop",   1'b0, 10'h000, 8'h00, 8'h0B, 24'h000000, 1'b1, 8,  64'hFF,         16'd4, 1'b1};
    vecs[5] = '{"afterbad",1'b0, 10'h000, 8'h00, 8'h03, 24'h000001, 1'b1, 16, 64'h2233,       16'd5, 1'b1};

    foreach (vecs[k]) begin
      if (vecs[k].ld_do) load(vecs[k].ld_a, vecs[k].ld_d);
      spi_read(vecs[k].op, vecs[k].addr, vecs[k].with_addr, vecs[k].dbits, rx, pre);
      check({vecs[k].name, "_rx"},  rx, vecs[k].exp_rx);
      check({vecs[k].name, "_pre"}, {63'd0, pre}, 64'd1);
      check({vecs[k].name, "_cnt"}, {48'd0, cmd_cnt}, {48'd0, vecs[k].exp_cnt});
      check({vecs[k].name, "_bad"}, {63'd0, bad_cmd}, {63'd0, vecs[k].exp_bad});
    end

    // Abort after 4 data bits, then re-read from address 1.
    spi_read(8'h03, 24'h000000, 1'b1, 4, rx, pre);
    check("abort_nibble", rx, 64'h5);
    check("abort_miso_cs_high", {63'd0, qspi_miso}, 64'd1);
    spi_read(8'h03, 24'h000001, 1'b1, 8, rx, pre);
    check("abort_reread", rx, 64'h22);
    check("abort_cnt", {48'd0, cmd_cnt}, 64'd7);

    // Reset in the middle of the address phase.
    qspi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 8; i++) spi_bit(op_read_bit(i), s);
    for (int i = 0; i < 10; i++) spi_bit(1'b0, s);
    sys_rst = 1'b1;
    wait_clk(1);
    sys_rst = 1'b0;
    wait_clk(1);
    check("rst_mid_cnt",  {48'd0, cmd_cnt},   64'd0);
    check("rst_mid_miso", {63'd0, qspi_miso}, 64'd1);
    check("rst_mid_bad",  {63'd0, bad_cmd},   64'd0);
    qspi_cs_n = 1'b1;
    wait_clk(8);
    spi_read(8'h03, 24'h000002, 1'b1, 8, rx, pre);
    check("rst_after_read", rx, 64'h33);
    check("rst_after_cnt", {48'd0, cmd_cnt}, 64'd1);

    cnt_model = 16'd1;
    bad_model = 1'b0;
    for (int t = 0; t < 14; t++) begin
      kind = $urandom_range(0, 3);
      nb   = $urandom_range(1, 4);
      addr = 24'($urandom);
      if (kind == 2) op = 8'h9F;
      else if (kind == 3) begin
        op = 8'($urandom);
        while (op == 8'h03 || op == 8'h9F) op = 8'($urandom);
      end else op = 8'h03;
      if ($urandom_range(0, 1) == 1) load(addr[9:0], 8'($urandom));
      spi_read(op, addr, (op != 8'h9F), nb * 8, rx, pre);
      if (op == 8'h03 || op == 8'h9F) cnt_model = cnt_model + 16'd1;
      else bad_model = 1'b1;
      check($sformatf("rand%0d_rx", t),  rx, model_read(op, addr, nb));
      check($sformatf("rand%0d_pre", t), {63'd0, pre}, 64'd1);
      check($sformatf("rand%0d_cnt", t), {48'd0, cmd_cnt}, {48'd0, cnt_model});
      check($sformatf("rand%0d_bad", t), {63'd0, bad_cmd}, {63'd0, bad_model});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  function automatic logic op_read_bit(input int i);
    logic [7:0] opc;
    opc = 8'h03;
    return opc[7-i];
  endfunction

endmodule
